fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address fetched first after reset.
REQ-002 Parameter QDEPTH, default 2, instruction-queue entries; legal range 1 to 4.
REQ-003 Clock is clk and reset is rst; one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req_valid  out  1  fetch request present.
REQ-007 imem_req_addr  out  32  word address being requested.
REQ-008 imem_req_ready  in  1  IMEM accepts request this cycle.
REQ-009 imem_rsp_valid  in  1  IMEM returns one instruction word.
REQ-010 imem_rsp_data  in  32  returned instruction.
REQ-011 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  in  32  new fetch target.
REQ-013 out_valid  out  1  inst/pc valid toward decode, control and immgen.
REQ-014 out_inst  out  32  instruction word, head of queue.
REQ-015 out_pc  out  32  address of out_inst.
REQ-016 out_ready  in  1  decode consumes head this cycle; low means stall.

Function
REQ-017 A request handshake occurs when imem_req_valid and imem_req_ready are both high; on a handshake, fetch pc advances by 4 the next cycle.
REQ-018 imem_req_valid = !rst && !redirect_valid && (count + inflight < QDEPTH); imem_req_addr = fetch pc.
REQ-019 IMEM responses are in order with latency of at least 1 cycle; inflight increments on a request handshake, decrements on imem_rsp_valid, and holds if both occur in the same cycle.
REQ-020 A response arriving while drop_cnt > 0 is discarded and decrements drop_cnt; otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc increments by 4.
REQ-021 out_valid = (count != 0); out_inst/out_pc = head entry; a pop occurs when out_valid and out_ready are both high.
REQ-022 A push and a pop in the same cycle leave count unchanged; the credit rule in REQ-018 guarantees that a push never meets a full queue.
REQ-023 Latency: a response in cycle N produces out_valid in cycle N+1 (registered queue, no bypass).
REQ-024 On redirect_valid in cycle N:
- the queue empties and out_valid is 0 in cycle N+1;
- fetch pc and rsp_pc load {redirect_pc[31:2], 2'b00};
- drop_cnt loads inflight minus imem_rsp_valid;
- any response in cycle N is discarded.
REQ-025 If a pop coincides with redirect_valid, the pop counts as consumed and the flush still clears all entries.
REQ-026 If redirect_valid is asserted on consecutive cycles, the last target wins and drop_cnt is recomputed each cycle.
REQ-027 While out_ready is low, out_inst and out_pc hold stable and requests stop once the credit reaches 0.
REQ-028 Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-029 In any cycle with rst high, the next state is: fetch pc = rsp_pc = RESET_PC, count = inflight = drop_cnt = 0, out_valid = 0, out_inst = 0, out_pc = 0.
REQ-030 imem_req_valid is 0 in every cycle rst is high.
REQ-031 rst overrides redirect and all handshakes; responses returned to requests issued before reset are not handled (the system resets IMEM together with this block).

Structure
REQ-032 The shared CPU package holds RESET_PC default, XLEN=32, NOP encoding 32'h0000_0013, and the opcode constants used by control and immgen.
REQ-033 The queue is one sub-module, fetch_queue: a synchronous FIFO with QDEPTH entries of 64 bits plus a flush input.

Verification
REQ-034 Scenario: rst released, imem_req_ready=1, 1-cycle IMEM returning 32'h00500093 then 32'h00A00113 -> out_pc 0 then 4 with those instructions, first out_valid 2 cycles after the first handshake.
REQ-035 Scenario: out_ready=0 for 6 cycles with QDEPTH=2 -> at most 2 handshakes; queue holds pc 0 and 4; pc 0 and 4 are delivered in order once out_ready=1.
REQ-036 Scenario: two requests in flight, redirect to 32'h0000_0100 -> both stale responses dropped; next out_pc = 32'h100.
REQ-037 Scenario: redirect_pc = 32'h0000_0103 -> imem_req_addr = 32'h0000_0100.
REQ-038 Scenario: redirect in the same cycle as a response and a pop -> response discarded; out_valid=0 next cycle; no duplicate output.
REQ-039 Scenario: fetch pc=32'hFFFF_FFFC with rst pulsed mid-stream -> fetch wraps to 0; after rst, first imem_req_addr = RESET_PC and out_valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_pkg : shared CPU constants, opcodes and fetch queue entry type
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_if : IMEM request/response, redirect and decode-side handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : synchronous FIFO of {pc, inst} entries with a flush input
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head reads as zero when empty so stale entries never leak out after reset.
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : credit-limited instruction fetch with redirect flush
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fe_if
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(QDEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_credit_used;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_keep;
  logic             w_q_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_rsp_dec;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // Outstanding requests reserve queue space so a response always finds a slot.
  assign w_credit_used = {1'b0, w_count} + {1'b0, inflight_q};
  assign w_req_valid   = !rst && !fe_if.redirect_valid && (w_credit_used < C_DEPTH);
  assign w_req_fire    = w_req_valid && fe_if.imem_req_ready;
  assign w_rsp_keep    = fe_if.imem_rsp_valid && !fe_if.redirect_valid && (drop_q == '0);
  assign w_rsp_dec     = CNT_W'(fe_if.imem_rsp_valid);
  assign w_pop         = w_q_valid && fe_if.out_ready;
  assign w_push_entry  = '{pc: rsp_pc_q, inst: fe_if.imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (fe_if.redirect_valid) begin
      // Every request still outstanding belongs to the old path.
      fetch_pc_d = align_word(fe_if.redirect_pc);
      rsp_pc_d   = align_word(fe_if.redirect_pc);
      inflight_d = inflight_q - w_rsp_dec;
      drop_d     = inflight_q - w_rsp_dec;
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (w_rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      if (fe_if.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      inflight_d = inflight_q + CNT_W'(w_req_fire) - w_rsp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (fe_if.redirect_valid),
    .push_i      (w_rsp_keep),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .valid_o     (w_q_valid),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign fe_if.imem_req_valid = w_req_valid;
  assign fe_if.imem_req_addr  = fetch_pc_q;
  assign fe_if.out_valid      = w_q_valid;
  assign fe_if.out_inst       = w_head.inst;
  assign fe_if.out_pc         = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed scenarios plus random soak against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          QD     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk   (clk),
    .rst   (rst),
    .fe_if (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } pend_t;

  // Environment: in-order IMEM with configurable latency
  pend_t       pend[$];
  // Reference model state
  logic [31:0] m_fetch_pc, m_rsp_pc;
  int          m_inflight, m_drop;
  logic [63:0] m_q[$];
  bit          m_zero, m_started;
  // Drive knobs
  logic        d_rst, d_ready, d_oready, d_redir, rv, e_req_valid;
  logic [31:0] d_rpc;
  bit          rand_en;
  int          lat_max;
  // Statistics
  longint      cyc;
  int          n_hs, n_chk, n_pass;
  longint      first_fire, first_ov;
  logic [63:0] delivered[$];

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_en) begin
      d_rst    = ($urandom_range(0, 299) == 0);
      d_ready  = ($urandom_range(0, 3) != 0);
      d_oready = ($urandom_range(0, 2) != 0);
      d_redir  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       d_rpc = 32'hFFFF_FFFC;
        1:       d_rpc = $urandom;
        2:       d_rpc = 32'h0000_0100;
        default: d_rpc = $urandom & 32'h0000_0FFF;
      endcase
    end
    rv = !d_rst && (pend.size() != 0) && (pend[0].due <= cyc) &&
         (!rand_en || ($urandom_range(0, 3) != 0));
    rst                 = d_rst;
    bus.imem_req_ready  = d_ready;
    bus.imem_rsp_valid  = rv;
    bus.imem_rsp_data   = rv ? imem_word(pend[0].addr) : $urandom;
    bus.redirect_valid  = d_redir;
    bus.redirect_pc     = d_rpc;
    bus.out_ready       = d_oready;
    #1;
    e_req_valid = !d_rst && !d_redir && ((m_q.size() + m_inflight) < QD);
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, e_req_valid});
    if (m_started) begin
      chk("req_addr", bus.imem_req_addr, m_fetch_pc);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
        chk("out_pc", bus.out_pc, m_q[0][63:32]);
        chk("out_inst", bus.out_inst, m_q[0][31:0]);
      end else if (m_zero) begin
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
      end
    end
    if (e_req_valid && d_ready && first_fire < 0) first_fire = cyc;
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (bus.out_valid && d_oready) delivered.push_back({bus.out_pc, bus.out_inst});
  endtask

  task automatic advance();
    logic fire;
    @(posedge clk);
    fire = e_req_valid && d_ready;
    if (fire) n_hs++;
    if (d_rst) pend.delete();
    else begin
      if (rv) void'(pend.pop_front());
      if (fire)
        pend.push_back('{addr: m_fetch_pc,
                         due: cyc + (rand_en ? $urandom_range(1, lat_max) : lat_max)});
    end
    if (d_rst) begin
      m_fetch_pc = RST_PC;
      m_rsp_pc   = RST_PC;
      m_inflight = 0;
      m_drop     = 0;
      m_q.delete();
      m_zero     = 1;
      m_started  = 1;
    end else if (d_redir) begin
      m_q.delete();
      m_fetch_pc = {d_rpc[31:2], 2'b00};
      m_rsp_pc   = {d_rpc[31:2], 2'b00};
      m_inflight = m_inflight - int'(rv);
      m_drop     = m_inflight;
    end else begin
      if (m_q.size() != 0 && d_oready) void'(m_q.pop_front());
      if (rv) begin
        m_inflight--;
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back({m_rsp_pc, bus.imem_rsp_data});
          m_rsp_pc += 32'd4;
          m_zero = 0;
        end
      end
      if (fire) begin
        m_fetch_pc += 32'd4;
        m_inflight++;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      advance();
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    run(2);
    d_rst = 1'b0;
    first_fire = -1;
    first_ov   = -1;
    n_hs       = 0;
    delivered.delete();
  endtask

  initial begin
    bit saw;
    n_chk = 0; n_pass = 0; cyc = 0; n_hs = 0;
    m_fetch_pc = RST_PC; m_rsp_pc = RST_PC; m_inflight = 0; m_drop = 0;
    m_zero = 1; m_started = 0;
    rand_en = 0; lat_max = 1;
    d_ready = 1'b1; d_oready = 1'b1; d_redir = 1'b0; d_rpc = 32'h0; rv = 1'b0;
    first_fire = -1; first_ov = -1;

    // Reset values, then back-to-back fetch with a 1-cycle IMEM
    do_reset();
    run(8);
    chk("s1_first_latency", 32'(first_ov - first_fire), 32'd2);
    chk("s1_delivered_ge2", {31'b0, delivered.size() >= 2}, 32'd1);
    if (delivered.size() >= 2) begin
      chk("s1_pc0", delivered[0][63:32], 32'h0);
      chk("s1_inst0", delivered[0][31:0], 32'h0050_0093);
      chk("s1_pc1", delivered[1][63:32], 32'h4);
      chk("s1_inst1", delivered[1][31:0], 32'h00A0_0113);
    end

    // Decode stall: credit limits handshakes to queue depth
    do_reset();
    d_oready = 1'b0;
    run(6);
    chk("s2_handshakes", 32'(n_hs), 32'd2);
    d_oready = 1'b1;
    run(3);
    chk("s2_delivered_ge2", {31'b0, delivered.size() >= 2}, 32'd1);
    if (delivered.size() >= 2) begin
      chk("s2_pc0", delivered[0][63:32], 32'h0);
      chk("s2_pc1", delivered[1][63:32], 32'h4);
    end

    // Two stale requests in flight when redirect to 0x100 arrives
    lat_max = 3;
    do_reset();
    run(2);
    d_redir = 1'b1; d_rpc = 32'h0000_0100;
    run(1);
    d_redir = 1'b0;
    delivered.delete();
    for (int i = 0; i < 16 && delivered.size() == 0; i++) run(1);
    chk("s3_delivered", {31'b0, delivered.size() != 0}, 32'd1);
    if (delivered.size() != 0) begin
      chk("s3_pc", delivered[0][63:32], 32'h0000_0100);
      chk("s3_inst", delivered[0][31:0], imem_word(32'h0000_0100));
    end

    // Unaligned redirect target, wrap at the top of memory, reset mid-stream
    lat_max = 1;
    d_redir = 1'b1; d_rpc = 32'h0000_0103;
    run(1);
    d_redir = 1'b0;
    step();
    chk("s4_align", bus.imem_req_addr, 32'h0000_0100);
    advance();
    run(3);
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFFC;
    run(1);
    d_redir = 1'b0;
    saw = 0;
    for (int i = 0; i < 6 && !saw; i++) begin
      step();
      if (e_req_valid && d_ready) saw = 1;
      advance();
    end
    chk("s5_wrap_handshake", {31'b0, saw}, 32'd1);
    step();
    chk("s5_wrap_addr", bus.imem_req_addr, 32'h0);
    advance();
    run(2);
    d_rst = 1'b1;
    step();
    chk("s6_req_in_rst", {31'b0, bus.imem_req_valid}, 32'd0);
    advance();
    d_rst = 1'b0;
    step();
    chk("s6_post_rst_addr", bus.imem_req_addr, RST_PC);
    chk("s6_post_rst_ov", {31'b0, bus.out_valid}, 32'd0);
    advance();

    // Random soak
    rand_en = 1;
    lat_max = 3;
    run(4000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
